// File: rtl/secmem_access_ctrl.sv
// Access controller for a small secure memory: lifecycle-aware policy check at
// request acceptance, one-shot memory strobes, read timeout and scrubbed responses.

`ifndef SECURE_MEMORY_WIDTH
`define SECURE_MEMORY_WIDTH 256
`endif
`ifndef SECURE_MEMORY_LENGTH
`define SECURE_MEMORY_LENGTH 8
`endif

module secmem_access_ctrl #(
    parameter int WIDTH   = `SECURE_MEMORY_WIDTH,
    parameter int LENGTH  = `SECURE_MEMORY_LENGTH,
    parameter int TIMEOUT = 16,
    localparam int AW     = (LENGTH > 1) ? $clog2(LENGTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    // client request
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [AW-1:0]    req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    input  logic [1:0]       lc_state,
    // client response
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [1:0]       rsp_err,
    // secure memory
    output logic             mem_rd_en,
    output logic             mem_wr_en,
    output logic [AW-1:0]    mem_addr,
    output logic [WIDTH-1:0] mem_wrData,
    input  logic [WIDTH-1:0] mem_rdData,
    input  logic             mem_rdData_valid
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_DENIED  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR_ISSUE,
        RESP
    } state_e;

    state_e             state_q;
    logic               req_ready_q;
    logic               rsp_valid_q;
    logic [WIDTH-1:0]   rsp_data_q;
    logic [1:0]         rsp_err_q;
    logic               mem_rd_en_q;
    logic               mem_wr_en_q;
    logic [AW-1:0]      mem_addr_q;
    logic [WIDTH-1:0]   mem_wrData_q;
    logic [CNT_W-1:0]   wait_cnt_q;

    logic               req_allow;
    logic [31:0]        addr_ext;
    logic [31:0]        lc_window;

    // Lifecycle policy, evaluated on the live request inputs; its verdict is
    // folded into the next state, so the lifecycle stage needs no later copy.
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        addr_ext  = 32'(req_addr);
        lc_window = 32'd4 + 32'(lc_state);
        req_allow = 1'b1;
        if (req_write) begin
            req_allow = (addr_ext < 32'd2);
        end else if (addr_ext == 32'd3 && lc_state == 2'd3) begin
            req_allow = 1'b0;
        end else if (addr_ext >= 32'd4 && addr_ext <= 32'd7 && addr_ext != lc_window) begin
            req_allow = 1'b0;
        end
    end

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_err_q    <= ERR_OK;
            mem_rd_en_q  <= 1'b0;
            mem_wr_en_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wrData_q <= '0;
            wait_cnt_q   <= '0;
        end else begin
            // Memory strobes and their address/data live for a single cycle.
            mem_rd_en_q  <= 1'b0;
            mem_wr_en_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wrData_q <= '0;

            case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_ready_q && req_valid) begin
                        req_ready_q <= 1'b0;
                        if (!req_allow) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= '0;
                            rsp_err_q   <= ERR_DENIED;
                        end else if (req_write) begin
                            state_q      <= WR_ISSUE;
                            mem_wr_en_q  <= 1'b1;
                            mem_addr_q   <= req_addr;
                            mem_wrData_q <= req_wdata;
                        end else begin
                            state_q     <= RD_ISSUE;
                            mem_rd_en_q <= 1'b1;
                            mem_addr_q  <= req_addr;
                        end
                    end
                end

                RD_ISSUE: begin
                    state_q    <= RD_WAIT;
                    wait_cnt_q <= '0;
                end

                RD_WAIT: begin
                    if (mem_rdData_valid) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= mem_rdData;
                        rsp_err_q   <= ERR_OK;
                    end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= '0;
                        rsp_err_q   <= ERR_TIMEOUT;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end

                WR_ISSUE: begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= '0;
                    rsp_err_q   <= ERR_OK;
                end

                RESP: begin
                    // Scrub the response on handshake so no key material lingers.
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_data_q  <= '0;
                        rsp_err_q   <= ERR_OK;
                    end
                end

                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    rsp_data_q  <= '0;
                    rsp_err_q   <= ERR_OK;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign mem_rd_en  = mem_rd_en_q;
    assign mem_wr_en  = mem_wr_en_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wrData = mem_wrData_q;

endmodule

// File: tb/tb_secmem_access_ctrl.sv
// Self-checking bench for secmem_access_ctrl: directed scenarios plus randomized
// traffic checked against a rule-level model of policy, latency and memory contents.

module tb_secmem_access_ctrl;

    localparam int WIDTH   = 256;
    localparam int LENGTH  = 8;
    localparam int AW      = 3;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid, req_ready, req_write;
    logic [AW-1:0]    req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic [1:0]       lc_state;
    logic             rsp_valid, rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic [1:0]       rsp_err;
    logic             mem_rd_en, mem_wr_en;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_wrData, mem_rdData;
    logic             mem_rdData_valid;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    secmem_access_ctrl #(.WIDTH(WIDTH), .LENGTH(LENGTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .lc_state(lc_state),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wrData(mem_wrData), .mem_rdData(mem_rdData), .mem_rdData_valid(mem_rdData_valid)
    );

    function automatic logic [WIDTH-1:0] init_word(input int i);
        case (i)
            2:       return 256'h49361d1e_7a2c4b90_d35e8f61_02b7c4a8_9e1f3d57_64a0b2c9_f18d2e73_0c13ef1b;
            5:       return {8{32'h8e307018}};
            default: return {8{32'hc0de0000 + 32'(i)}};
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] rand_word();
        logic [WIDTH-1:0] w;
        for (int k = 0; k < WIDTH / 32; k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    // Rule-level access policy
    function automatic bit ref_allowed(input bit w, input int a, input int lc);
        if (w) return a < 2;
        if (a == 3 && lc == 3) return 1'b0;
        if (a >= 4 && a <= 7 && a != 4 + lc) return 1'b0;
        return 1'b1;
    endfunction

    // Secure memory environment: registered read data, one cycle after mem_rd_en.
    logic [WIDTH-1:0] env_mem [LENGTH];
    logic             env_loaded     = 1'b0;
    logic             mem_valid_q    = 1'b0;
    logic [WIDTH-1:0] mem_data_q     = '0;
    logic             tie_valid_zero = 1'b0;
    logic             spurious       = 1'b0;
    logic [WIDTH-1:0] junk           = '0;

    always @(posedge clk) begin
        if (!env_loaded) begin
            for (int i = 0; i < LENGTH; i++) env_mem[i] <= init_word(i);
            env_loaded <= 1'b1;
        end else if (mem_wr_en) begin
            env_mem[mem_addr] <= mem_wrData;
        end
        mem_valid_q <= mem_rd_en;
        mem_data_q  <= mem_rd_en ? env_mem[mem_addr] : '0;
    end

    assign mem_rdData_valid = (mem_valid_q && !tie_valid_zero) || spurious;
    assign mem_rdData       = spurious ? junk : mem_data_q;

    // Expected memory contents
    logic [WIDTH-1:0] ref_mem [LENGTH];

    typedef struct {
        int               rd_pulses;
        int               wr_pulses;
        logic [AW-1:0]    pulse_addr;
        logic [WIDTH-1:0] pulse_wdata;
        int               first_rsp;
        int               resp_cycles;
        logic [WIDTH-1:0] rsp_data;
        logic [1:0]       rsp_err;
        bit               unstable;
        bit               overlap;
        bit               idle_nonzero;
        bit               ready_busy;
        bit               not_cleared;
        bit               hung;
    } obs_t;

    // Drives one transaction and records what the DUT did; cycle 1 is the cycle
    // after the acceptance edge. Inputs are scrambled after acceptance.
    task automatic run_txn(input bit w, input int addr, input logic [WIDTH-1:0] wd,
                           input int lc, input int delay, output obs_t o);
        int c;
        int resp_cnt;
        bit done;
        o = '{default: '0};
        o.first_rsp = -1;
        c = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && c < 50) begin
            @(negedge clk);
            c++;
        end
        if (req_ready !== 1'b1) begin
            o.hung = 1'b1;
            return;
        end
        req_valid = 1'b1;
        req_write = w;
        req_addr  = AW'(addr);
        req_wdata = wd;
        lc_state  = 2'(lc);
        rsp_ready = (delay == 0);
        @(posedge clk);
        c = 0;
        resp_cnt = 0;
        done = 1'b0;
        while (!done && c < 100) begin
            @(negedge clk);
            c++;
            req_valid = 1'b0;
            req_write = 1'($urandom);
            req_addr  = AW'($urandom);
            req_wdata = rand_word();
            lc_state  = 2'($urandom);
            if (mem_rd_en && mem_wr_en) o.overlap = 1'b1;
            if (mem_rd_en) begin
                o.rd_pulses++;
                o.pulse_addr = mem_addr;
            end
            if (mem_wr_en) begin
                o.wr_pulses++;
                o.pulse_addr  = mem_addr;
                o.pulse_wdata = mem_wrData;
            end
            if (!mem_rd_en && !mem_wr_en && mem_addr !== '0) o.idle_nonzero = 1'b1;
            if (!mem_wr_en && mem_wrData !== '0) o.idle_nonzero = 1'b1;
            if (rsp_valid === 1'b1) begin
                if (o.first_rsp < 0) begin
                    o.first_rsp = c;
                    o.rsp_data  = rsp_data;
                    o.rsp_err   = rsp_err;
                end else if (rsp_data !== o.rsp_data || rsp_err !== o.rsp_err) begin
                    o.unstable = 1'b1;
                end
                if (req_ready !== 1'b0) o.ready_busy = 1'b1;
                resp_cnt++;
                o.resp_cycles = resp_cnt;
                if (resp_cnt > delay) rsp_ready = 1'b1;
            end else if (o.first_rsp >= 0) begin
                done = 1'b1;
                if (rsp_data !== '0 || rsp_err !== 2'b00 || req_ready !== 1'b1) o.not_cleared = 1'b1;
            end else if (req_ready !== 1'b0 || rsp_data !== '0 || rsp_err !== 2'b00) begin
                o.ready_busy = 1'b1;
            end
        end
        if (!done) o.hung = 1'b1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({req_ready, rsp_valid, rsp_err, mem_rd_en, mem_wr_en} !== 6'b0 ||
            rsp_data !== '0 || mem_addr !== '0 || mem_wrData !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got ready=%b valid=%b err=%b rd=%b wr=%b, required all 0",
                     req_ready, rsp_valid, rsp_err, mem_rd_en, mem_wr_en);
        end
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (req_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release_ready: got %b before first edge, required 0", req_ready);
        end
        @(negedge clk);
        tests_run++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_first_edge: got ready=%b valid=%b, required ready=1 valid=0",
                     req_ready, rsp_valid);
        end
    endtask

    task automatic test_read_basic();
        obs_t o;
        run_txn(1'b0, 2, rand_word(), 0, 0, o);
        tests_run++;
        if (o.rd_pulses != 1 || o.wr_pulses != 0 || o.pulse_addr !== 3'd2) begin
            tests_failed++;
            $display("FAIL read2_strobe: got rd=%0d wr=%0d addr=%0d, required rd=1 wr=0 addr=2",
                     o.rd_pulses, o.wr_pulses, o.pulse_addr);
        end
        tests_run++;
        if (o.first_rsp != 3 || o.resp_cycles != 1) begin
            tests_failed++;
            $display("FAIL read2_latency: got first=%0d len=%0d, required first=3 len=1",
                     o.first_rsp, o.resp_cycles);
        end
        tests_run++;
        if (o.rsp_data !== ref_mem[2] || o.rsp_err !== 2'b00) begin
            tests_failed++;
            $display("FAIL read2_data: got %h err=%b, required %h err=00", o.rsp_data, o.rsp_err, ref_mem[2]);
        end
        tests_run++;
        if (o.not_cleared || o.overlap || o.idle_nonzero || o.hung) begin
            tests_failed++;
            $display("FAIL read2_protocol: got flags clr=%b ovl=%b idle=%b hung=%b, required 0000",
                     o.not_cleared, o.overlap, o.idle_nonzero, o.hung);
        end
    endtask

    task automatic test_lc_window();
        obs_t o;
        run_txn(1'b0, 5, rand_word(), 1, 0, o);
        tests_run++;
        if (o.rsp_data !== {8{32'h8e307018}} || o.rsp_err !== 2'b00 || o.rd_pulses != 1) begin
            tests_failed++;
            $display("FAIL read5_lc1: got %h err=%b rd=%0d, required 8e307018x8 err=00 rd=1",
                     o.rsp_data, o.rsp_err, o.rd_pulses);
        end
        run_txn(1'b0, 5, rand_word(), 2, 0, o);
        tests_run++;
        if (o.rsp_data !== '0 || o.rsp_err !== 2'b01 || o.rd_pulses != 0 || o.first_rsp != 1) begin
            tests_failed++;
            $display("FAIL read5_lc2_denied: got %h err=%b rd=%0d first=%0d, required 0 err=01 rd=0 first=1",
                     o.rsp_data, o.rsp_err, o.rd_pulses, o.first_rsp);
        end
        run_txn(1'b0, 3, rand_word(), 3, 0, o);
        tests_run++;
        if (o.rsp_err !== 2'b01 || o.rd_pulses != 0) begin
            tests_failed++;
            $display("FAIL read3_lc3_denied: got err=%b rd=%0d, required err=01 rd=0", o.rsp_err, o.rd_pulses);
        end
    endtask

    task automatic test_write_readback();
        obs_t o;
        logic [WIDTH-1:0] a5;
        a5 = {32{8'hA5}};
        run_txn(1'b1, 0, a5, 0, 0, o);
        tests_run++;
        if (o.wr_pulses != 1 || o.rd_pulses != 0 || o.pulse_addr !== 3'd0 || o.pulse_wdata !== a5) begin
            tests_failed++;
            $display("FAIL write0_strobe: got wr=%0d rd=%0d addr=%0d data=%h, required wr=1 rd=0 addr=0 data=%h",
                     o.wr_pulses, o.rd_pulses, o.pulse_addr, o.pulse_wdata, a5);
        end
        tests_run++;
        if (o.rsp_err !== 2'b00 || o.rsp_data !== '0 || o.first_rsp != 2) begin
            tests_failed++;
            $display("FAIL write0_resp: got err=%b data=%h first=%0d, required err=00 data=0 first=2",
                     o.rsp_err, o.rsp_data, o.first_rsp);
        end
        ref_mem[0] = a5;
        run_txn(1'b0, 0, rand_word(), 0, 0, o);
        tests_run++;
        if (o.rsp_data !== a5 || o.rsp_err !== 2'b00) begin
            tests_failed++;
            $display("FAIL read0_after_write: got %h err=%b, required %h err=00", o.rsp_data, o.rsp_err, a5);
        end
        run_txn(1'b1, 3, rand_word(), 0, 0, o);
        tests_run++;
        if (o.rsp_err !== 2'b01 || o.wr_pulses != 0 || o.first_rsp != 1) begin
            tests_failed++;
            $display("FAIL write3_denied: got err=%b wr=%0d first=%0d, required err=01 wr=0 first=1",
                     o.rsp_err, o.wr_pulses, o.first_rsp);
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        tie_valid_zero = 1'b1;
        run_txn(1'b0, 1, rand_word(), 0, 0, o);
        tie_valid_zero = 1'b0;
        tests_run++;
        if (o.rsp_err !== 2'b10 || o.rsp_data !== '0 || o.rd_pulses != 1) begin
            tests_failed++;
            $display("FAIL timeout_resp: got err=%b data=%h rd=%0d, required err=10 data=0 rd=1",
                     o.rsp_err, o.rsp_data, o.rd_pulses);
        end
        tests_run++;
        if (o.first_rsp != 2 + TIMEOUT) begin
            tests_failed++;
            $display("FAIL timeout_latency: got first=%0d, required %0d", o.first_rsp, 2 + TIMEOUT);
        end
    endtask

    task automatic test_backpressure();
        obs_t o;
        run_txn(1'b0, 2, rand_word(), 0, 5, o);
        tests_run++;
        if (o.resp_cycles != 6 || o.unstable || o.ready_busy) begin
            tests_failed++;
            $display("FAIL backpressure_hold: got len=%0d unstable=%b ready_busy=%b, required len=6 0 0",
                     o.resp_cycles, o.unstable, o.ready_busy);
        end
        tests_run++;
        if (o.rsp_data !== ref_mem[2] || o.not_cleared) begin
            tests_failed++;
            $display("FAIL backpressure_data: got %h cleared_bad=%b, required %h cleared_bad=0",
                     o.rsp_data, o.not_cleared, ref_mem[2]);
        end
    endtask

    task automatic test_spurious_valid();
        obs_t o;
        logic [WIDTH-1:0] wd;
        wd = rand_word();
        @(negedge clk);
        junk = rand_word();
        spurious = 1'b1;
        repeat (3) @(negedge clk);
        run_txn(1'b1, 1, wd, 2, 0, o);
        tests_run++;
        if (o.rsp_err !== 2'b00 || o.rsp_data !== '0 || o.first_rsp != 2 || o.wr_pulses != 1) begin
            tests_failed++;
            $display("FAIL spurious_write: got err=%b data=%h first=%0d wr=%0d, required 00 0 2 1",
                     o.rsp_err, o.rsp_data, o.first_rsp, o.wr_pulses);
        end
        ref_mem[1] = wd;
        run_txn(1'b0, 6, rand_word(), 0, 0, o);
        tests_run++;
        if (o.rsp_err !== 2'b01 || o.rsp_data !== '0 || o.first_rsp != 1) begin
            tests_failed++;
            $display("FAIL spurious_denied: got err=%b data=%h first=%0d, required 01 0 1",
                     o.rsp_err, o.rsp_data, o.first_rsp);
        end
        spurious = 1'b0;
        run_txn(1'b0, 1, rand_word(), 0, 0, o);
        tests_run++;
        if (o.rsp_data !== wd || o.rsp_err !== 2'b00 || o.first_rsp != 3) begin
            tests_failed++;
            $display("FAIL spurious_readback: got %h err=%b first=%0d, required %h 00 3",
                     o.rsp_data, o.rsp_err, o.first_rsp, wd);
        end
    endtask

    task automatic test_random();
        obs_t o;
        bit w, allowed;
        int addr, lc, delay, exp_first;
        logic [WIDTH-1:0] wd, exp_data;
        for (int n = 0; n < 40; n++) begin
            w     = 1'($urandom_range(0, 1));
            addr  = $urandom_range(0, LENGTH - 1);
            if (w && $urandom_range(0, 1) == 1) addr = $urandom_range(0, 1);
            lc    = $urandom_range(0, 3);
            delay = $urandom_range(0, 3);
            wd    = rand_word();
            allowed   = ref_allowed(w, addr, lc);
            exp_first = !allowed ? 1 : (w ? 2 : 3);
            exp_data  = (allowed && !w) ? ref_mem[addr] : '0;
            run_txn(w, addr, wd, lc, delay, o);
            tests_run++;
            if (o.rsp_err !== (allowed ? 2'b00 : 2'b01) || o.rsp_data !== exp_data) begin
                tests_failed++;
                $display("FAIL rand%0d_resp w=%0d a=%0d lc=%0d: got err=%b data=%h, required err=%b data=%h",
                         n, w, addr, lc, o.rsp_err, o.rsp_data, allowed ? 2'b00 : 2'b01, exp_data);
            end
            tests_run++;
            if (o.first_rsp != exp_first || o.resp_cycles != delay + 1) begin
                tests_failed++;
                $display("FAIL rand%0d_timing: got first=%0d len=%0d, required first=%0d len=%0d",
                         n, o.first_rsp, o.resp_cycles, exp_first, delay + 1);
            end
            tests_run++;
            if (o.rd_pulses != int'(allowed && !w) || o.wr_pulses != int'(allowed && w) ||
                (allowed && o.pulse_addr !== AW'(addr)) || (allowed && w && o.pulse_wdata !== wd)) begin
                tests_failed++;
                $display("FAIL rand%0d_strobe: got rd=%0d wr=%0d addr=%0d, required rd=%0d wr=%0d addr=%0d",
                         n, o.rd_pulses, o.wr_pulses, o.pulse_addr,
                         int'(allowed && !w), int'(allowed && w), addr);
            end
            tests_run++;
            if ({o.overlap, o.idle_nonzero, o.ready_busy, o.unstable, o.not_cleared, o.hung} !== 6'b0) begin
                tests_failed++;
                $display("FAIL rand%0d_protocol: got ovl=%b idle=%b busy=%b unst=%b clr=%b hung=%b, required all 0",
                         n, o.overlap, o.idle_nonzero, o.ready_busy, o.unstable, o.not_cleared, o.hung);
            end
            if (allowed && w) ref_mem[addr] = wd;
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        int c;
        bit stale;
        tie_valid_zero = 1'b1;
        c = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && c < 50) begin
            @(negedge clk);
            c++;
        end
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 3'd1;
        lc_state  = 2'd0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({req_ready, rsp_valid, rsp_err, mem_rd_en, mem_wr_en} !== 6'b0 ||
            rsp_data !== '0 || mem_addr !== '0 || mem_wrData !== '0) begin
            tests_failed++;
            $display("FAIL midreset_outputs: got ready=%b valid=%b err=%b rd=%b wr=%b addr=%0d, required all 0",
                     req_ready, rsp_valid, rsp_err, mem_rd_en, mem_wr_en, mem_addr);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tie_valid_zero = 1'b0;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_release: got ready=%b valid=%b, required ready=1 valid=0", req_ready, rsp_valid);
        end
        stale = 1'b0;
        repeat (TIMEOUT + 4) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) stale = 1'b1;
        end
        rsp_ready = 1'b0;
        tests_run++;
        if (stale) begin
            tests_failed++;
            $display("FAIL midreset_stale: got stale response or busy after reset, required idle");
        end
        run_txn(1'b0, 0, rand_word(), 0, 0, o);
        tests_run++;
        if (o.rsp_data !== ref_mem[0] || o.rsp_err !== 2'b00 || o.first_rsp != 3) begin
            tests_failed++;
            $display("FAIL midreset_recover: got %h err=%b first=%0d, required %h 00 3",
                     o.rsp_data, o.rsp_err, o.first_rsp, ref_mem[0]);
        end
    endtask

    initial begin
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        lc_state  = 2'd0;
        rsp_ready = 1'b0;
        for (int i = 0; i < LENGTH; i++) ref_mem[i] = init_word(i);
        test_reset();
        test_read_basic();
        test_lc_window();
        test_write_readback();
        test_timeout();
        test_backpressure();
        test_spurious_valid();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
